// File: rtl/dac_frame_scheduler.sv
`default_nettype none
// dac_frame_scheduler: paces 24-bit DAC frames for four round-robin channels.
// Each channel's code comes from a 64-entry sine ROM indexed by a shared base phase plus that channel's offset.

module dac_frame_scheduler #(
  parameter int CLK_DIV      = 32,
  parameter int PHASE_STEP_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [7:0]              burst_len,
  input  logic [PHASE_STEP_W-1:0] phase_step,
  input  logic [PHASE_STEP_W-1:0] ch_offset0,
  input  logic [PHASE_STEP_W-1:0] ch_offset1,
  input  logic [PHASE_STEP_W-1:0] ch_offset2,
  input  logic [PHASE_STEP_W-1:0] ch_offset3,
  output logic                    trigger,
  output logic [7:0]              header,
  output logic [15:0]             code,
  output logic                    busy,
  output logic                    burst_done
);

  localparam int SLOT_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, DONE} state_t;

  state_t                  state, state_nxt;
  logic                    enable_q;
  logic [7:0]              len_q;
  logic [PHASE_STEP_W-1:0] step_q, off0_q, off1_q, off2_q, off3_q;
  logic [PHASE_STEP_W-1:0] base, index, cur_off;
  logic [PHASE_STEP_W:0]   base_sum;
  logic [1:0]              ch;
  logic [SLOT_W-1:0]       slot_cnt;
  logic [7:0]              period_cnt, period_nxt;
  logic                    slot_end, start;

  function automatic logic [15:0] sine_rom(input logic [5:0] idx);
    case (idx)
      6'd0:  sine_rom = 16'h8000; 6'd1:  sine_rom = 16'h8C8B; 6'd2:  sine_rom = 16'h98F8; 6'd3:  sine_rom = 16'hA527;
      6'd4:  sine_rom = 16'hB0FB; 6'd5:  sine_rom = 16'hBC56; 6'd6:  sine_rom = 16'hC71C; 6'd7:  sine_rom = 16'hD133;
      6'd8:  sine_rom = 16'hDA82; 6'd9:  sine_rom = 16'hE2F1; 6'd10: sine_rom = 16'hEA6D; 6'd11: sine_rom = 16'hF0E2;
      6'd12: sine_rom = 16'hF641; 6'd13: sine_rom = 16'hFA7C; 6'd14: sine_rom = 16'hFD89; 6'd15: sine_rom = 16'hFF61;
      6'd16: sine_rom = 16'hFFFF; 6'd17: sine_rom = 16'hFF61; 6'd18: sine_rom = 16'hFD89; 6'd19: sine_rom = 16'hFA7C;
      6'd20: sine_rom = 16'hF641; 6'd21: sine_rom = 16'hF0E2; 6'd22: sine_rom = 16'hEA6D; 6'd23: sine_rom = 16'hE2F1;
      6'd24: sine_rom = 16'hDA82; 6'd25: sine_rom = 16'hD133; 6'd26: sine_rom = 16'hC71C; 6'd27: sine_rom = 16'hBC56;
      6'd28: sine_rom = 16'hB0FB; 6'd29: sine_rom = 16'hA527; 6'd30: sine_rom = 16'h98F8; 6'd31: sine_rom = 16'h8C8B;
      6'd32: sine_rom = 16'h8000; 6'd33: sine_rom = 16'h7374; 6'd34: sine_rom = 16'h6707; 6'd35: sine_rom = 16'h5AD8;
      6'd36: sine_rom = 16'h4F04; 6'd37: sine_rom = 16'h43A9; 6'd38: sine_rom = 16'h38E3; 6'd39: sine_rom = 16'h2ECC;
      6'd40: sine_rom = 16'h257D; 6'd41: sine_rom = 16'h1D0E; 6'd42: sine_rom = 16'h1592; 6'd43: sine_rom = 16'h0F1D;
      6'd44: sine_rom = 16'h09BE; 6'd45: sine_rom = 16'h0583; 6'd46: sine_rom = 16'h0276; 6'd47: sine_rom = 16'h009E;
      6'd48: sine_rom = 16'h0000; 6'd49: sine_rom = 16'h009E; 6'd50: sine_rom = 16'h0276; 6'd51: sine_rom = 16'h0583;
      6'd52: sine_rom = 16'h09BE; 6'd53: sine_rom = 16'h0F1D; 6'd54: sine_rom = 16'h1592; 6'd55: sine_rom = 16'h1D0E;
      6'd56: sine_rom = 16'h257D; 6'd57: sine_rom = 16'h2ECC; 6'd58: sine_rom = 16'h38E3; 6'd59: sine_rom = 16'h43A9;
      6'd60: sine_rom = 16'h4F04; 6'd61: sine_rom = 16'h5AD8; 6'd62: sine_rom = 16'h6707; 6'd63: sine_rom = 16'h7374;
      default: sine_rom = 16'h8000;
    endcase
  endfunction

  always_comb begin
    cur_off = off0_q;
    case (ch)
      2'd1:    cur_off = off1_q;
      2'd2:    cur_off = off2_q;
      2'd3:    cur_off = off3_q;
      default: cur_off = off0_q;
    endcase
  end

  assign index      = base + cur_off;
  assign base_sum   = {1'b0, base} + {1'b0, step_q};
  assign period_nxt = period_cnt + {7'd0, base_sum[PHASE_STEP_W]};
  // WAIT lasts CLK_DIV-2 cycles so FIRE + WAIT + LOAD spans exactly CLK_DIV.
  assign slot_end   = (slot_cnt == SLOT_W'(CLK_DIV - 3));
  assign start      = enable && !enable_q;

  assign trigger    = (state == FIRE);
  assign busy       = (state != IDLE);
  assign burst_done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = FIRE;
      FIRE: state_nxt = WAIT;
      WAIT: begin
        if (slot_end) begin
          if (ch == 2'd3 && (((len_q != 8'd0) && (period_nxt == len_q)) || !enable))
            state_nxt = DONE;
          else
            state_nxt = LOAD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      enable_q   <= 1'b0;
      len_q      <= '0;
      step_q     <= '0;
      off0_q     <= '0;
      off1_q     <= '0;
      off2_q     <= '0;
      off3_q     <= '0;
      base       <= '0;
      ch         <= '0;
      slot_cnt   <= '0;
      period_cnt <= '0;
      header     <= '0;
      code       <= '0;
    end else begin
      state    <= state_nxt;
      enable_q <= enable;
      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= burst_len;
            step_q     <= phase_step;
            off0_q     <= ch_offset0;
            off1_q     <= ch_offset1;
            off2_q     <= ch_offset2;
            off3_q     <= ch_offset3;
            base       <= '0;
            ch         <= '0;
            period_cnt <= '0;
          end
        end
        LOAD: begin
          header <= 8'h10 | {5'd0, ch, 1'b0};
          code   <= sine_rom(index);
        end
        FIRE: slot_cnt <= '0;
        WAIT: begin
          slot_cnt <= slot_cnt + 1'b1;
          if (slot_end) begin
            if (ch == 2'd3) begin
              ch         <= '0;
              base       <= base_sum[PHASE_STEP_W-1:0];
              period_cnt <= period_nxt;
            end else begin
              ch <= ch + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dac_frame_scheduler.sv
`default_nettype none
// tb_dac_frame_scheduler: directed checks of trigger pacing, headers, sine codes, burst end and reset.

module tb_dac_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  burst_len;
  logic [5:0]  phase_step, ch_offset0, ch_offset1, ch_offset2, ch_offset3;
  logic        trigger;
  logic [7:0]  header;
  logic [15:0] code;
  logic        busy;
  logic        burst_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] tr_code [0:63];
  logic [7:0]  tr_hdr  [0:63];
  int          tr_cyc  [0:63];

  dac_frame_scheduler #(.CLK_DIV(32), .PHASE_STEP_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .burst_len  (burst_len),
    .phase_step (phase_step),
    .ch_offset0 (ch_offset0),
    .ch_offset1 (ch_offset1),
    .ch_offset2 (ch_offset2),
    .ch_offset3 (ch_offset3),
    .trigger    (trigger),
    .header     (header),
    .code       (code),
    .busy       (busy),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  // Raises enable, then logs every trigger until 100 cycles past the first burst_done.
  task automatic run_burst(input int max_cyc, input int drop_after,
                           output int ntrig, output int ndone, output int done_cyc,
                           output logic busy_at_done, output logic busy_after, output bit timeout);
    bit seen_done;
    ntrig = 0; ndone = 0; done_cyc = -1;
    busy_at_done = 1'b0; busy_after = 1'b1; timeout = 1'b1; seen_done = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (trigger) begin
        if (ntrig < 64) begin
          tr_code[ntrig] = code;
          tr_hdr[ntrig]  = header;
          tr_cyc[ntrig]  = c;
        end
        ntrig++;
        if (ntrig == drop_after) enable = 1'b0;
      end
      if (seen_done && c == done_cyc + 1) busy_after = busy;
      if (burst_done) begin
        ndone++;
        if (!seen_done) begin
          seen_done    = 1'b1;
          done_cyc     = c;
          busy_at_done = busy;
        end
      end
      if (seen_done && c >= done_cyc + 100) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int ntrig, nbusy;
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (trigger !== 1'b0)  $display("FAIL reset_trigger got %b want 0", trigger); else pass_cnt++;
    total_cnt++; if (header !== 8'h00)  $display("FAIL reset_header got %h want 00", header); else pass_cnt++;
    total_cnt++; if (code !== 16'h0000) $display("FAIL reset_code got %h want 0000", code); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)     $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (burst_done !== 1'b0) $display("FAIL reset_done got %b want 0", burst_done); else pass_cnt++;
    rst = 1'b0;
    ntrig = 0; nbusy = 0;
    repeat (200) begin
      @(negedge clk);
      if (trigger) ntrig++;
      if (busy) nbusy++;
    end
    total_cnt++; if (ntrig + nbusy !== 0) $display("FAIL idle_activity got %0d want 0", ntrig + nbusy); else pass_cnt++;
  endtask

  task automatic test_continuous();
    int ntrig, ndone, dcyc;
    logic bd, ba;
    bit to;
    logic [7:0]  exp_hdr  [0:3];
    logic [15:0] exp_code [0:3];
    exp_hdr  = '{8'h10, 8'h12, 8'h14, 8'h16};
    exp_code = '{16'h8000, 16'h0F1D, 16'hFF61, 16'h38E3};
    burst_len = 8'd0; phase_step = 6'd16;
    ch_offset0 = 6'd0; ch_offset1 = 6'd43; ch_offset2 = 6'd15; ch_offset3 = 6'd38;
    run_burst(600, 5, ntrig, ndone, dcyc, bd, ba, to);
    total_cnt++; if (to !== 1'b0) $display("FAIL cont_timeout got %b want 0", to); else pass_cnt++;
    total_cnt++; if (tr_cyc[0] !== 2) $display("FAIL cont_first_trig_cycle got %0d want 2", tr_cyc[0]); else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      total_cnt++;
      if (tr_cyc[i] - tr_cyc[i-1] !== 32) $display("FAIL cont_spacing%0d got %0d want 32", i, tr_cyc[i] - tr_cyc[i-1]); else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (tr_hdr[i] !== exp_hdr[i]) $display("FAIL cont_header%0d got %h want %h", i, tr_hdr[i], exp_hdr[i]); else pass_cnt++;
      total_cnt++;
      if (tr_code[i] !== exp_code[i]) $display("FAIL cont_code%0d got %h want %h", i, tr_code[i], exp_code[i]); else pass_cnt++;
    end
    total_cnt++; if (tr_code[4] !== 16'hFFFF) $display("FAIL cont_fifth_code got %h want FFFF", tr_code[4]); else pass_cnt++;
    total_cnt++; if (ntrig !== 8) $display("FAIL cont_stop_triggers got %0d want 8", ntrig); else pass_cnt++;
    total_cnt++; if (ndone !== 1) $display("FAIL cont_done_pulses got %0d want 1", ndone); else pass_cnt++;
  endtask

  task automatic test_burst_one();
    int ntrig, ndone, dcyc;
    logic bd, ba;
    bit to;
    burst_len = 8'd1; phase_step = 6'd16;
    ch_offset0 = 6'd0; ch_offset1 = 6'd0; ch_offset2 = 6'd0; ch_offset3 = 6'd0;
    run_burst(2000, 0, ntrig, ndone, dcyc, bd, ba, to);
    total_cnt++; if (to !== 1'b0) $display("FAIL b1_timeout got %b want 0", to); else pass_cnt++;
    total_cnt++; if (ntrig !== 16) $display("FAIL b1_triggers got %0d want 16", ntrig); else pass_cnt++;
    total_cnt++; if (ndone !== 1) $display("FAIL b1_done_pulses got %0d want 1", ndone); else pass_cnt++;
    total_cnt++; if (dcyc - tr_cyc[15] !== 31) $display("FAIL b1_done_delay got %0d want 31", dcyc - tr_cyc[15]); else pass_cnt++;
    total_cnt++; if (bd !== 1'b1) $display("FAIL b1_busy_at_done got %b want 1", bd); else pass_cnt++;
    total_cnt++; if (ba !== 1'b0) $display("FAIL b1_busy_after_done got %b want 0", ba); else pass_cnt++;
    total_cnt++; if (tr_code[4] !== 16'hFFFF)  $display("FAIL b1_code_base16 got %h want FFFF", tr_code[4]); else pass_cnt++;
    total_cnt++; if (tr_code[8] !== 16'h8000)  $display("FAIL b1_code_base32 got %h want 8000", tr_code[8]); else pass_cnt++;
    total_cnt++; if (tr_code[12] !== 16'h0000) $display("FAIL b1_code_base48 got %h want 0000", tr_code[12]); else pass_cnt++;
    run_burst(2000, 0, ntrig, ndone, dcyc, bd, ba, to);
    total_cnt++; if (ntrig !== 16) $display("FAIL b1_restart_triggers got %0d want 16", ntrig); else pass_cnt++;
    total_cnt++; if (tr_code[0] !== 16'h8000) $display("FAIL b1_restart_code got %h want 8000", tr_code[0]); else pass_cnt++;
    enable = 1'b0;
  endtask

  task automatic test_step24();
    int ntrig, ndone, dcyc;
    logic bd, ba;
    bit to;
    burst_len = 8'd2; phase_step = 6'd24;
    ch_offset0 = 6'd0; ch_offset1 = 6'd0; ch_offset2 = 6'd0; ch_offset3 = 6'd0;
    run_burst(2000, 0, ntrig, ndone, dcyc, bd, ba, to);
    // Rounds at bases 0,24,48,8,32,56; the update 56->16 is the second carry and ends the burst.
    total_cnt++; if (ntrig !== 24) $display("FAIL s24_triggers got %0d want 24", ntrig); else pass_cnt++;
    total_cnt++; if (ndone !== 1) $display("FAIL s24_done_pulses got %0d want 1", ndone); else pass_cnt++;
    total_cnt++; if (tr_code[8] !== 16'h0000)  $display("FAIL s24_code_base48 got %h want 0000", tr_code[8]); else pass_cnt++;
    total_cnt++; if (tr_code[12] !== 16'hDA82) $display("FAIL s24_code_base8 got %h want DA82", tr_code[12]); else pass_cnt++;
    total_cnt++; if (tr_code[20] !== 16'h257D) $display("FAIL s24_code_base56 got %h want 257D", tr_code[20]); else pass_cnt++;
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    int ntrig, ndone, dcyc;
    logic bd, ba;
    bit to;
    burst_len = 8'd0; phase_step = 6'd8;
    ch_offset0 = 6'd1; ch_offset1 = 6'd2; ch_offset2 = 6'd3; ch_offset3 = 6'd4;
    run_burst(2000, 10, ntrig, ndone, dcyc, bd, ba, to);
    total_cnt++; if (ntrig !== 12) $display("FAIL drop_triggers got %0d want 12", ntrig); else pass_cnt++;
    total_cnt++; if (ndone !== 1) $display("FAIL drop_done_pulses got %0d want 1", ndone); else pass_cnt++;
    total_cnt++; if (tr_code[0] !== 16'h8C8B) $display("FAIL drop_first_code got %h want 8C8B", tr_code[0]); else pass_cnt++;
    total_cnt++; if (tr_hdr[11] !== 8'h16) $display("FAIL drop_last_header got %h want 16", tr_hdr[11]); else pass_cnt++;
    total_cnt++; if (tr_code[11] !== 16'hF641) $display("FAIL drop_last_code got %h want F641", tr_code[11]); else pass_cnt++;
    total_cnt++; if (dcyc - tr_cyc[11] !== 31) $display("FAIL drop_done_delay got %0d want 31", dcyc - tr_cyc[11]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit got;
    int nact;
    burst_len = 8'd0; phase_step = 6'd16;
    ch_offset0 = 6'd0; ch_offset1 = 6'd0; ch_offset2 = 6'd0; ch_offset3 = 6'd0;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (trigger) got = 1'b1;
    end
    total_cnt++; if (got !== 1'b1) $display("FAIL rmid_first_trigger got %b want 1", got); else pass_cnt++;
    repeat (5) @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    total_cnt++; if (trigger !== 1'b0)  $display("FAIL rmid_trigger got %b want 0", trigger); else pass_cnt++;
    total_cnt++; if (header !== 8'h00)  $display("FAIL rmid_header got %h want 00", header); else pass_cnt++;
    total_cnt++; if (code !== 16'h0000) $display("FAIL rmid_code got %h want 0000", code); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)     $display("FAIL rmid_busy got %b want 0", busy); else pass_cnt++;
    rst = 1'b0;
    nact = 0;
    repeat (200) begin
      @(negedge clk);
      if (trigger || busy || burst_done) nact++;
    end
    total_cnt++; if (nact !== 0) $display("FAIL rmid_idle_activity got %0d want 0", nact); else pass_cnt++;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (trigger !== 1'b1) $display("FAIL rmid_restart_trigger got %b want 1", trigger); else pass_cnt++;
    total_cnt++; if (header !== 8'h10) $display("FAIL rmid_restart_header got %h want 10", header); else pass_cnt++;
    enable = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (burst_done) got = 1'b1;
    end
    total_cnt++; if (got !== 1'b1) $display("FAIL rmid_final_done got %b want 1", got); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; burst_len = 8'd0; phase_step = 6'd0;
    ch_offset0 = 6'd0; ch_offset1 = 6'd0; ch_offset2 = 6'd0; ch_offset3 = 6'd0;
    test_reset();
    test_continuous();
    test_burst_one();
    test_step24();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
